// File: rtl/tt_mux_pgseq.sv
// Row mux with power-gate sequencer: one UM of the row is powered, enabled and
// wired to the spine at a time; switching goes through isolate/power-down/power-up.
module tt_mux_pgseq #(
   parameter int N_UM       = 16,
   parameter int N_IO       = 8,
   parameter int N_O        = 8,
   parameter int N_I        = 10,
   parameter int GRP        = 4,
   parameter int ADDR_W     = 4,
   parameter int PG_ON_CYC  = 16,
   parameter int PG_OFF_CYC = 4,
   parameter bit OUT_REG    = 1'b1,
   localparam int U_OW      = N_O + 2*N_IO,
   localparam int U_IW      = N_I + N_IO,
   localparam int SW        = (N_UM > 1) ? $clog2(N_UM) : 1
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic [U_OW*N_UM-1:0]   um_ow_i,
   output logic [U_IW*N_UM-1:0]   um_iw_o,
   output logic [N_UM-1:0]        um_ena_o,
   output logic [N_UM-1:0]        um_pg_vdd_o,
   input  logic [U_IW-1:0]        spine_iw_i,
   input  logic [ADDR_W+SW-1:0]   spine_sel_i,
   input  logic                   spine_ena_i,
   input  logic [ADDR_W-1:0]      addr_i,
   output logic [U_OW-1:0]        spine_ow_o,
   output logic [SW-1:0]          cur_sel_o,
   output logic                   active_o
);

   localparam int N_GRP = (N_UM + GRP - 1) / GRP;

   typedef enum logic [1:0] {
      S_IDLE,
      S_PWR_UP,
      S_ACTIVE,
      S_ISOLATE
   } state_t;

   state_t            state_q, state_d;
   logic [SW-1:0]     cur_sel_q, cur_sel_d;
   logic [7:0]        cnt_q, cnt_d;
   logic [U_OW-1:0]   spine_ow_q, spine_ow_d;

   logic [SW-1:0]     tgt;
   logic [ADDR_W-1:0] sel_row;
   logic              tgt_vld;

   assign tgt     = spine_sel_i[SW-1:0];
   assign sel_row = spine_sel_i[ADDR_W+SW-1:SW];
   assign tgt_vld = spine_ena_i && (sel_row == addr_i) && (int'(tgt) < N_UM);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= S_IDLE;
         cur_sel_q  <= '0;
         cnt_q      <= '0;
         spine_ow_q <= '0;
      end else begin
         state_q    <= state_d;
         cur_sel_q  <= cur_sel_d;
         cnt_q      <= cnt_d;
         spine_ow_q <= spine_ow_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cur_sel_d = cur_sel_q;
      cnt_d     = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (tgt_vld) begin
               cur_sel_d = tgt;
               cnt_d     = 8'(PG_ON_CYC - 1);
               state_d   = S_PWR_UP;
            end
         end
         S_PWR_UP: begin
            if (cnt_q == 8'd0) state_d = S_ACTIVE;
            else               cnt_d   = cnt_q - 8'd1;
         end
         S_ACTIVE: begin
            if (!tgt_vld || (tgt != cur_sel_q)) begin
               cnt_d   = 8'(PG_OFF_CYC - 1);
               state_d = S_ISOLATE;
            end
         end
         S_ISOLATE: begin
            if (cnt_q == 8'd0) state_d = S_IDLE;
            else               cnt_d   = cnt_q - 8'd1;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Per-UM controls: only the selected UM ever sees power, enable or data.
   always_comb begin
      um_pg_vdd_o = '1;
      um_ena_o    = '0;
      um_iw_o     = '0;
      for (int i = 0; i < N_UM; i++) begin
         if (cur_sel_q == SW'(i)) begin
            um_pg_vdd_o[i] = (state_q == S_IDLE);
            um_ena_o[i]    = (state_q == S_ACTIVE);
            if (state_q == S_ACTIVE) um_iw_o[U_IW*i +: U_IW] = spine_iw_i;
         end
      end
   end

   // Zero-padded so the last, possibly partial, group needs no range guards.
   logic [U_OW*N_GRP*GRP-1:0] um_ow_pad;
   logic [U_OW-1:0]           grp_mux [N_GRP];
   logic [U_OW-1:0]           mux_ow;

   assign um_ow_pad = (U_OW*N_GRP*GRP)'(um_ow_i);

   always_comb begin
      for (int g = 0; g < N_GRP; g++) begin
         grp_mux[g] = '0;
         for (int k = 0; k < GRP; k++) begin
            if ((int'(cur_sel_q) % GRP) == k) grp_mux[g] = um_ow_pad[U_OW*(g*GRP+k) +: U_OW];
         end
      end
      mux_ow = '0;
      for (int g = 0; g < N_GRP; g++) begin
         if ((int'(cur_sel_q) / GRP) == g) mux_ow = grp_mux[g];
      end
   end

   // Capture only while ACTIVE persists so the cycle after leaving ACTIVE reads 0.
   assign spine_ow_d = (state_q == S_ACTIVE && state_d == S_ACTIVE) ? mux_ow : '0;

   generate
      if (OUT_REG) begin : g_oreg
         assign spine_ow_o = spine_ow_q;
      end else begin : g_ocomb
         assign spine_ow_o = (state_q == S_ACTIVE) ? mux_ow : '0;
      end
   endgenerate

   assign cur_sel_o = cur_sel_q;
   assign active_o  = (state_q == S_ACTIVE);

endmodule

// File: tb/tb_tt_mux_pgseq.sv
// Scoreboard bench for tt_mux_pgseq: directed then random target/reset segments,
// checked cycle by cycle against a power-age reference model.
module tb_tt_mux_pgseq;

   localparam int N_UM       = 13;
   localparam int N_IO       = 8;
   localparam int N_O        = 8;
   localparam int N_I        = 10;
   localparam int GRP        = 4;
   localparam int ADDR_W     = 4;
   localparam int PG_ON_CYC  = 16;
   localparam int PG_OFF_CYC = 4;
   localparam int U_OW       = N_O + 2*N_IO;
   localparam int U_IW       = N_I + N_IO;
   localparam int SW         = 4;
   localparam int MY_ADDR    = 3;

   logic                  clk = 1'b0;
   logic                  rst;
   logic [U_OW*N_UM-1:0]  um_ow;
   logic [U_IW*N_UM-1:0]  um_iw;
   logic [N_UM-1:0]       um_ena;
   logic [N_UM-1:0]       um_pg_vdd;
   logic [U_IW-1:0]       spine_iw;
   logic [ADDR_W+SW-1:0]  spine_sel;
   logic                  spine_ena;
   logic [ADDR_W-1:0]     addr;
   logic [U_OW-1:0]       spine_ow;
   logic [SW-1:0]         cur_sel;
   logic                  active;

   tt_mux_pgseq #(
      .N_UM(N_UM), .N_IO(N_IO), .N_O(N_O), .N_I(N_I), .GRP(GRP), .ADDR_W(ADDR_W),
      .PG_ON_CYC(PG_ON_CYC), .PG_OFF_CYC(PG_OFF_CYC), .OUT_REG(1'b1)
   ) dut (
      .clk_i(clk), .rst_i(rst), .um_ow_i(um_ow), .um_iw_o(um_iw), .um_ena_o(um_ena),
      .um_pg_vdd_o(um_pg_vdd), .spine_iw_i(spine_iw), .spine_sel_i(spine_sel),
      .spine_ena_i(spine_ena), .addr_i(addr), .spine_ow_o(spine_ow),
      .cur_sel_o(cur_sel), .active_o(active)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [N_UM-1:0]      pg;
      logic [N_UM-1:0]      ena;
      logic [U_IW*N_UM-1:0] iw;
      logic [U_OW-1:0]      ow;
      logic [SW-1:0]        cs;
      logic                 act;
   } exp_t;

   typedef struct {
      bit r;
      bit en;
      int row;
      int idx;
      int len;
   } seg_t;

   exp_t exp_q[$];
   seg_t segs[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   // Reference model: which UM holds power, how long it has been powered,
   // and how many isolation cycles remain before it is released.
   int m_pwr  = -1;
   int m_age  = 0;
   int m_iso  = 0;
   int m_last = 0;

   function automatic bit m_active();
      return (m_pwr >= 0) && (m_iso == 0) && (m_age >= PG_ON_CYC);
   endfunction

   function automatic void m_step(input bit r, input bit tv, input int tg);
      if (r) begin
         m_pwr = -1; m_age = 0; m_iso = 0; m_last = 0;
      end else if (m_pwr < 0) begin
         if (tv) begin m_pwr = tg; m_last = tg; m_age = 0; end
      end else if (m_iso > 0) begin
         m_iso--;
         if (m_iso == 0) m_pwr = -1;
      end else if (m_age < PG_ON_CYC) begin
         m_age++;
      end else if (!tv || tg != m_pwr) begin
         m_iso = PG_OFF_CYC;
      end
   endfunction

   task automatic push_expected(input bit r, input bit en, input int row, input int idx);
      exp_t e;
      bit   tv;
      bit   was;
      tv  = en && (row == MY_ADDR) && (idx < N_UM);
      was = m_active();
      m_step(r, tv, idx);
      e.pg  = '1;
      e.ena = '0;
      e.iw  = '0;
      e.ow  = '0;
      e.act = m_active();
      e.cs  = SW'(m_last);
      if (m_pwr >= 0) e.pg[m_pwr] = 1'b0;
      if (e.act) begin
         e.ena[m_pwr] = 1'b1;
         e.iw[U_IW*m_pwr +: U_IW] = spine_iw;
         if (was) e.ow = um_ow[U_OW*m_pwr +: U_OW];
      end
      exp_q.push_back(e);
   endtask

   task automatic chk(input string nm, input logic [255:0] act_v, input logic [255:0] exp_v);
      n_tests++;
      if (act_v !== exp_v) begin
         n_fail++;
         $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act_v, exp_v);
      end
   endtask

   // Monitor: every cycle the DUT presents a new output set.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("pg_vdd",   256'(um_pg_vdd), 256'(e.pg));
            chk("um_ena",   256'(um_ena),    256'(e.ena));
            chk("um_iw",    256'(um_iw),     256'(e.iw));
            chk("spine_ow", 256'(spine_ow),  256'(e.ow));
            chk("cur_sel",  256'(cur_sel),   256'(e.cs));
            chk("active",   256'(active),    256'(e.act));
         end
      end
   end

   task automatic drive(input seg_t s);
      for (int c = 0; c < s.len; c++) begin
         @(negedge clk);
         for (int i = 0; i < N_UM; i++) um_ow[U_OW*i +: U_OW] = U_OW'($urandom);
         spine_iw  = U_IW'($urandom);
         rst       = s.r;
         spine_ena = s.en;
         spine_sel = (ADDR_W+SW)'(s.row * (1 << SW) + s.idx);
         push_expected(s.r, s.en, s.row, s.idx);
      end
   endtask

   initial begin
      seg_t s;
      int   last_idx;
      rst = 1'b1; spine_ena = 1'b0; spine_sel = '0; addr = ADDR_W'(MY_ADDR);
      um_ow = '0; spine_iw = '0;
      push_expected(1'b1, 1'b0, 0, 0);

      segs.push_back('{1, 0, 0, 0, 2});
      segs.push_back('{0, 1, 3, 5, 30});   // power up and run UM 5
      segs.push_back('{0, 1, 3, 9, 30});   // retarget to UM 9
      segs.push_back('{0, 1, 2, 5, 12});   // wrong row
      segs.push_back('{0, 1, 3, 14, 8});   // index beyond N_UM
      segs.push_back('{0, 0, 3, 14, 8});
      segs.push_back('{0, 1, 3, 7, 7});    // reset in the middle of power-up
      segs.push_back('{1, 1, 3, 7, 1});
      segs.push_back('{0, 0, 3, 7, 4});
      segs.push_back('{0, 1, 3, 12, 6});   // last, partial group; drop during power-up
      segs.push_back('{0, 0, 3, 12, 30});
      segs.push_back('{0, 1, 3, 12, 30});
      foreach (segs[i]) drive(segs[i]);

      last_idx = 12;
      for (int n = 0; n < 60; n++) begin
         int kind;
         kind  = $urandom_range(0, 11);
         s.r   = 0;
         s.en  = 1;
         s.row = MY_ADDR;
         s.idx = last_idx;
         s.len = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 5) : $urandom_range(6, 45);
         case (kind)
            0, 1, 2, 3: s.idx = $urandom_range(0, N_UM - 1);
            4, 5:       s.idx = last_idx;
            6:          s.en  = 0;
            7:          s.row = (MY_ADDR + $urandom_range(1, 15)) % 16;
            8:          s.idx = $urandom_range(N_UM, 15);
            9:          begin s.r = 1; s.len = $urandom_range(1, 3); end
            default:    begin s.en = ($urandom_range(0, 1) == 1); s.idx = $urandom_range(0, 15); end
         endcase
         if (s.idx < N_UM) last_idx = s.idx;
         drive(s);
      end

      @(negedge clk);
      for (int w = 0; w < 5 && exp_q.size() > 0; w++) @(negedge clk);
      n_tests++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
